// File: rtl/ascon_perm_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : ascon_perm_stream_adapter
// Purpose  : word-serial load/unload wrapper around the 320-bit Ascon permutation
// Revision : 1.0  initial release
// ============================================================================
module ascon_perm_stream_adapter #(
  parameter  int W  = 64,      // stream word width, 32 or 64
  localparam int NW = 320 / W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         err,
  output logic         perm_start,
  output logic         perm_reset,
  output logic [319:0] perm_in,
  input  logic         perm_done,
  input  logic [319:0] perm_out
);

  localparam int            CW     = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NW - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [319:0]  st_q;
  logic [319:0]  res_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          err_q;
  logic          start_q;
  logic          preset_q;

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_last;

  assign w_in_xfer  = in_valid & in_ready_q;
  assign w_out_xfer = out_valid_q & out_ready;
  assign w_last     = (cnt_q == C_LAST);

  // Words enter at the bottom and shift up, so the first word ends in [319 -: W];
  // the result register shifts the same way so its top word is always the next out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      st_q        <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      preset_q    <= 1'b1;
    end else begin
      preset_q <= 1'b0;
      start_q  <= 1'b0;
      if (perm_done && (state_q != S_WAIT)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_LOAD: begin
          if (w_in_xfer) begin
            st_q <= {st_q[319-W:0], in_data};
            if (w_last) begin
              cnt_q      <= '0;
              state_q    <= S_START;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              start_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_START: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (perm_done) begin
            res_q       <= perm_out;
            state_q     <= S_UNLOAD;
            out_valid_q <= 1'b1;
          end
        end
        S_UNLOAD: begin
          if (w_out_xfer) begin
            res_q <= {res_q[319-W:0], {W{1'b0}}};
            if (w_last) begin
              cnt_q       <= '0;
              state_q     <= S_LOAD;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = res_q[319 -: W];
  assign busy       = busy_q;
  assign err        = err_q;
  assign perm_start = start_q;
  assign perm_reset = preset_q;
  assign perm_in    = st_q;

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_perm_stream_adapter
// Purpose  : directed + randomized bench for both stream widths, with a core model
// Revision : 1.0  initial release
// ============================================================================
module tb_ascon_perm_stream_adapter;

  localparam logic [319:0] C_K = {5{64'h0123_4567_89ab_cdef}};

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [63:0]  in_data64, out_data64;
  logic         in_valid64, in_ready64, out_valid64, out_ready64;
  logic         busy64, err64, start64, preset64, done64, core_done64, inj_done64;
  logic [319:0] perm_in64, perm_out64;
  int           lat64;

  logic [31:0]  in_data32, out_data32;
  logic         in_valid32, in_ready32, out_valid32, out_ready32;
  logic         busy32, err32, start32, preset32, done32;
  logic [319:0] perm_in32, perm_out32;
  int           lat32;

  assign done64 = core_done64 | inj_done64;

  ascon_perm_stream_adapter #(.W(64)) u_dut64 (
    .clk(clk), .reset_n(rst_n),
    .in_data(in_data64), .in_valid(in_valid64), .in_ready(in_ready64),
    .out_data(out_data64), .out_valid(out_valid64), .out_ready(out_ready64),
    .busy(busy64), .err(err64), .perm_start(start64), .perm_reset(preset64),
    .perm_in(perm_in64), .perm_done(done64), .perm_out(perm_out64)
  );

  ascon_perm_stream_adapter #(.W(32)) u_dut32 (
    .clk(clk), .reset_n(rst_n),
    .in_data(in_data32), .in_valid(in_valid32), .in_ready(in_ready32),
    .out_data(out_data32), .out_valid(out_valid32), .out_ready(out_ready32),
    .busy(busy32), .err(err32), .perm_start(start32), .perm_reset(preset32),
    .perm_in(perm_in32), .perm_done(done32), .perm_out(perm_out32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in permutation: any fixed bijection exercises the data path equally well.
  function automatic logic [319:0] fperm(input logic [319:0] s);
    return {s[306:0], s[319:307]} ^ C_K;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic irdy(input bit s); return s ? in_ready32 : in_ready64; endfunction
  function automatic logic ovld(input bit s); return s ? out_valid32 : out_valid64; endfunction
  function automatic logic bsy(input bit s);  return s ? busy32 : busy64; endfunction
  function automatic logic [63:0] odat(input bit s);
    return s ? {32'h0, out_data32} : out_data64;
  endfunction
  function automatic int nwords(input bit s); return s ? 10 : 5; endfunction

  task automatic set_ordy(input bit s, input logic v);
    if (s) out_ready32 = v; else out_ready64 = v;
  endtask

  task automatic set_in(input bit s, input logic v, input logic [63:0] d);
    if (s) begin in_valid32 = v; in_data32 = d[31:0]; end
    else   begin in_valid64 = v; in_data64 = d;       end
  endtask

  // Core models: latch perm_in on start, answer after lat cycles, abandon on reset.
  initial begin : core64
    logic [319:0] snap;
    bit live;
    core_done64 = 1'b0;
    perm_out64  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && start64) begin
        snap = perm_in64;
        live = 1'b1;
        for (int i = 0; i < lat64 && live; i++) begin
          @(negedge clk);
          if (!rst_n) live = 1'b0;
        end
        if (live) begin
          chk("w64_perm_in_hold", perm_in64, snap);
          chk("w64_no_out_in_wait", out_valid64, 1'b0);
          perm_out64  = fperm(snap);
          core_done64 = 1'b1;
          @(negedge clk);
          core_done64 = 1'b0;
          perm_out64  = '0;
          chk("w64_done_to_valid", out_valid64, 1'b1);
        end
      end
    end
  end

  initial begin : core32
    logic [319:0] snap;
    bit live;
    done32     = 1'b0;
    perm_out32 = '0;
    forever begin
      @(negedge clk);
      if (rst_n && start32) begin
        snap = perm_in32;
        live = 1'b1;
        for (int i = 0; i < lat32 && live; i++) begin
          @(negedge clk);
          if (!rst_n) live = 1'b0;
        end
        if (live) begin
          chk("w32_perm_in_hold", perm_in32, snap);
          perm_out32 = fperm(snap);
          done32     = 1'b1;
          @(negedge clk);
          done32     = 1'b0;
          perm_out32 = '0;
          chk("w32_done_to_valid", out_valid32, 1'b1);
        end
      end
    end
  end

  task automatic put(input bit s, input logic [63:0] w);
    int n;
    n = 0;
    set_in(s, 1'b1, w);
    while (!irdy(s) && n < 200) begin @(negedge clk); n++; end
    chk("in_ready_wait", n < 200, 1'b1);
    @(negedge clk);
    set_in(s, 1'b0, w);
  endtask

  task automatic load(input bit s, input bit gaps, output logic [319:0] st);
    logic [63:0] w;
    st = '0;
    for (int k = 0; k < nwords(s); k++) begin
      w = {$urandom, $urandom};
      if (s) begin w[63:32] = '0; st[319-k*32 -: 32] = w[31:0]; end
      else   st[319-k*64 -: 64] = w;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      put(s, w);
    end
  endtask

  task automatic unload(input bit s, input logic [319:0] st, input int stall_at);
    logic [319:0] r;
    logic [63:0]  e;
    int n;
    r = fperm(st);
    set_in(s, 1'b1, '1);
    for (int k = 0; k < nwords(s); k++) begin
      e = s ? {32'h0, r[319-k*32 -: 32]} : r[319-k*64 -: 64];
      n = 0;
      while (!ovld(s) && n < 200) begin @(negedge clk); n++; end
      chk("out_valid_wait", n < 200, 1'b1);
      chk("in_ready_low_unload", irdy(s), 1'b0);
      if (k == stall_at) begin
        repeat (7) begin
          @(negedge clk);
          chk("stall_hold", {ovld(s), odat(s)}, {1'b1, e});
        end
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      chk("out_word", odat(s), e);
      set_ordy(s, 1'b1);
      @(negedge clk);
      set_ordy(s, 1'b0);
    end
    set_in(s, 1'b0, '0);
    chk("busy_after_unload", bsy(s), 1'b0);
    chk("in_ready_after_unload", irdy(s), 1'b1);
    chk("out_valid_after_unload", ovld(s), 1'b0);
  endtask

  initial begin : main
    logic [319:0] st;
    logic [63:0]  w;
    total = 0; bad = 0;
    in_data64 = '0; in_valid64 = 1'b0; out_ready64 = 1'b0; inj_done64 = 1'b0;
    in_data32 = '0; in_valid32 = 1'b0; out_ready32 = 1'b0;
    lat64 = 3; lat32 = 3;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_in_ready", in_ready64, 1'b1);
    chk("rst_busy", busy64, 1'b0);
    chk("rst_out_valid", out_valid64, 1'b0);
    chk("rst_err", err64, 1'b0);
    chk("rst_start", start64, 1'b0);
    chk("rst_perm_reset", preset64, 1'b1);
    chk("rst_perm_in", perm_in64, '0);
    chk("rst_out_data", out_data64, '0);
    chk("rst_perm_in32", perm_in32, '0);
    rst_n = 1'b1;
    #1 chk("perm_reset_after_release", preset64, 1'b1);
    @(negedge clk);
    chk("perm_reset_falls", preset64, 1'b0);

    // back-to-back load of words 1..5
    for (int k = 1; k <= 5; k++) begin
      chk("t1_in_ready", in_ready64, 1'b1);
      put(1'b0, 64'(k));
    end
    chk("t1_start_pulse", start64, 1'b1);
    chk("t1_perm_in", perm_in64, {64'h1, 64'h2, 64'h3, 64'h4, 64'h5});
    chk("t1_busy", busy64, 1'b1);
    chk("t1_in_ready_low", in_ready64, 1'b0);
    @(negedge clk);
    chk("t1_start_single", start64, 1'b0);
    unload(1'b0, {64'h1, 64'h2, 64'h3, 64'h4, 64'h5}, -1);

    // random data, input gaps and a 7-cycle output stall
    repeat (3) begin
      lat64 = $urandom_range(1, 20);
      load(1'b0, 1'b1, st);
      unload(1'b0, st, 2);
    end
    chk("err_clean_w64", err64, 1'b0);

    // 32-bit stream
    lat32 = 5;
    load(1'b1, 1'b1, st);
    chk("w32_start", start32, 1'b1);
    chk("w32_perm_in", perm_in32, st);
    unload(1'b1, st, 4);
    chk("err_clean_w32", err32, 1'b0);

    // reset while waiting on the core
    lat64 = 1000;
    load(1'b0, 1'b0, st);
    repeat (20) @(negedge clk);
    chk("t5_busy_wait", busy64, 1'b1);
    chk("t5_in_ready_wait", in_ready64, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_in_ready", in_ready64, 1'b1);
    chk("t5_busy", busy64, 1'b0);
    chk("t5_out_valid", out_valid64, 1'b0);
    chk("t5_perm_reset", preset64, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t5_perm_reset_hold", preset64, 1'b1);
    @(negedge clk);
    chk("t5_perm_reset_low", preset64, 1'b0);
    lat64 = 4;
    load(1'b0, 1'b1, st);
    unload(1'b0, st, -1);

    // stray perm_done during LOAD
    lat64 = 2;
    st = '0;
    for (int k = 0; k < 5; k++) begin
      w = {$urandom, $urandom};
      st[319-k*64 -: 64] = w;
      if (k == 2) begin
        inj_done64 = 1'b1;
        @(negedge clk);
        inj_done64 = 1'b0;
        chk("t6_err_set", err64, 1'b1);
        chk("t6_still_load", {busy64, in_ready64}, 2'b01);
      end
      put(1'b0, w);
    end
    chk("t6_perm_in", perm_in64, st);
    unload(1'b0, st, 1);
    chk("t6_err_sticky", err64, 1'b1);
    rst_n = 1'b0;
    #1 chk("t6_err_cleared", err64, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
